oloca_sweep_ctrl: RTL
=====================

Name: oloca_sweep_ctrl

Overview:
- Hardware error-characterisation sequencer for an external WIDTH-bit approximate adder such as oloca_8bit.
- On start, it drives every operand pair (a,b) exhaustively into the adder and samples its sum.
- For each case it computes the error against the exact sum and accumulates ER/AE/MAE/MSE raw totals plus the maximum absolute error.
- It lets a characterisation run happen on-chip or in FPGA without a software testbench; division and normalisation stay in software.

Parameters:
- WIDTH, 8, operand width of the adder under test; adder sum is WIDTH+1 bits.
- Derived localparams, not overridable:
  - CNT_W = 2*WIDTH+1
  - ERR_W = WIDTH+2 (signed per-case error)
  - ABS_W = 3*WIDTH+2
  - SQ_W = 4*WIDTH+3

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- abort  in  1  terminate a running sweep.
- op_a  out  WIDTH  registered operand A to the adder.
- op_b  out  WIDTH  registered operand B to the adder.
- approx_sum  in  WIDTH+1  combinational adder result for current op_a/op_b.
- busy  out  1  high in SWEEP and DRAIN.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  sticky; set by abort, cleared by next accepted start.
- case_count  out  CNT_W  cases accumulated.
- err_count  out  CNT_W  cases with nonzero error.
- err_sum  out  ABS_W+1  signed sum of (approx-exact).
- abs_sum  out  ABS_W  sum of |error|.
- sq_sum  out  SQ_W  sum of error squared.
- max_abs  out  ERR_W  largest |error| seen.

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - All outputs 0: op_a, op_b, busy, done, aborted, all accumulators, max_abs.
  - Pipeline valid bit s_vld=0.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE:
  - start=1 at an edge: clear all accumulators and max_abs, clear aborted, set op_a=op_b=0, go SWEEP.
  - Results from the previous run hold until then.
- SWEEP:
  - Each edge, capture stage-1 values: s_err = zero-extended approx_sum minus (op_a+op_b) computed at WIDTH+1 bits, in ERR_W signed; set s_vld=1.
  - Same edge, advance operands: op_b+1. If op_b was all-ones, op_b wraps to 0 and op_a+1.
  - When op_a and op_b are both all-ones at the edge, capture the last case and go DRAIN; operands hold.
- Stage 2, every cycle with s_vld=1:
  - case_count+1.
  - err_count+1 if s_err≠0.
  - err_sum+=s_err (sign-extended).
  - abs_sum+=|s_err|.
  - sq_sum+=s_err².
  - max_abs=max(max_abs,|s_err|).
- DRAIN: one cycle. The final s_vld case accumulates; s_vld cleared; go DONE.
- DONE: done=1 for exactly this cycle; busy=0; go IDLE.
- Latency for WIDTH=8:
  - start accepted at edge 0; SWEEP occupies cycles 1..65536; DRAIN at cycle 65537; done high in cycle 65538.
  - General form: 2^(2·WIDTH)+2 cycles from start to done.
- busy is 1 exactly in SWEEP and DRAIN.
- start while busy or in DONE is ignored; it is not queued.
- abort in SWEEP or DRAIN:
  - Next state IDLE, s_vld cleared, aborted=1, done not pulsed.
  - Accumulators keep partial values, including any s_vld case accumulated that same edge.
  - abort in IDLE or DONE has no effect.
- abort and start asserted together in IDLE: start wins; aborted is cleared.
- No accumulator wraps: widths are sized for the full 2^(2·WIDTH) sweep at worst-case |error| = 2^(WIDTH+1)-1.
- approx_sum is sampled only in SWEEP; the controller assumes the adder settles within one cycle.
- Reset asserted mid-sweep clears everything immediately; no done pulse.

Test Plan:
- Adder model = exact sum, WIDTH=8, start pulse -> done in cycle 65538; case_count=65536; err_count=err_sum=abs_sum=sq_sum=max_abs=0; busy high cycles 1..65537.
- Adder model = exact+1 -> err_count=65536, err_sum=65536, abs_sum=65536, sq_sum=65536, max_abs=1.
- Adder model = constant 0 -> err_count=65535, err_sum=-16711680, abs_sum=16711680, sq_sum=4977295360, max_abs=510.
- Abort asserted in cycle 101 of SWEEP -> busy=0 next cycle, aborted=1, no done, case_count=100 or 101 consistent with the stage rule. A following start clears aborted and gives the full exact-model results.
- start pulsed again at cycle 500 during a sweep -> ignored; completion still at cycle 65538. rst_n pulled low mid-sweep -> all outputs 0 immediately.
- WIDTH=4 with the exact+1 model -> done in cycle 258, case_count=256, sq_sum=256.

Source files
------------

// File: rtl/oloca_sweep_ctrl_if.sv
// Bus between the sweep controller and its environment: host control,
// operand drive to the adder under test, adder result, and the result counters.
interface oloca_sweep_ctrl_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = 2*WIDTH + 1;
  localparam int ERR_W = WIDTH + 2;
  localparam int ABS_W = 3*WIDTH + 2;
  localparam int SQ_W  = 4*WIDTH + 3;

  logic                    start;
  logic                    abort;
  logic [WIDTH-1:0]        op_a;
  logic [WIDTH-1:0]        op_b;
  logic [WIDTH:0]          approx_sum;
  logic                    busy;
  logic                    done;
  logic                    aborted;
  logic [CNT_W-1:0]        case_count;
  logic [CNT_W-1:0]        err_count;
  logic signed [ABS_W:0]   err_sum;
  logic [ABS_W-1:0]        abs_sum;
  logic [SQ_W-1:0]         sq_sum;
  logic [ERR_W-1:0]        max_abs;

  // controller side
  modport slave (
    input  start, abort, approx_sum,
    output op_a, op_b, busy, done, aborted,
           case_count, err_count, err_sum, abs_sum, sq_sum, max_abs
  );

  // host plus adder side
  modport master (
    output start, abort, approx_sum,
    input  op_a, op_b, busy, done, aborted,
           case_count, err_count, err_sum, abs_sum, sq_sum, max_abs
  );
endinterface

// File: rtl/oloca_sweep_ctrl.sv
// Exhaustive error-characterisation sequencer for a WIDTH-bit approximate adder.
// Walks every (a,b) pair, computes approx-exact per case in a one-deep pipeline
// and accumulates raw ER/AE/MAE/MSE totals plus the worst |error|.
//
// state   | meaning
// S_IDLE  | waiting for start; previous results held
// S_SWEEP | one operand pair per cycle driven and captured
// S_DRAIN | last captured case accumulates
// S_DONE  | one-cycle done pulse
module oloca_sweep_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  oloca_sweep_ctrl_if.slave bus
);
  localparam int CNT_W = 2*WIDTH + 1;
  localparam int ERR_W = WIDTH + 2;
  localparam int ABS_W = 3*WIDTH + 2;
  localparam int SQ_W  = 4*WIDTH + 3;
  localparam int OPS_W = 2*WIDTH;
  localparam logic [OPS_W-1:0] OPS_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  state_t                   r_state, w_state_nxt;
  logic [OPS_W-1:0]         r_ops;
  logic                     r_s_vld;
  logic signed [ERR_W-1:0]  r_s_err;
  logic [CNT_W-1:0]         r_case_count, r_err_count;
  logic signed [ABS_W:0]    r_err_sum;
  logic [ABS_W-1:0]         r_abs_sum;
  logic [SQ_W-1:0]          r_sq_sum;
  logic [ERR_W-1:0]         r_max_abs;
  logic                     r_aborted;

  logic                     w_accept, w_active, w_run, w_last;
  logic [WIDTH:0]           w_exact;
  logic signed [ERR_W-1:0]  w_err;
  logic [ERR_W-1:0]         w_abs;
  logic [2*ERR_W-1:0]       w_sq;

  // op_a is the upper half of one 2*WIDTH counter so the b-wrap carries into a
  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_active = (r_state == S_SWEEP) || (r_state == S_DRAIN);
  assign w_run    = (r_state == S_SWEEP) && !bus.abort;
  assign w_last   = &r_ops;
  assign w_exact  = {1'b0, r_ops[OPS_W-1:WIDTH]} + {1'b0, r_ops[WIDTH-1:0]};
  assign w_err    = $signed({1'b0, bus.approx_sum}) - $signed({1'b0, w_exact});
  assign w_abs    = r_s_err[ERR_W-1] ? $unsigned(-r_s_err) : $unsigned(r_s_err);
  assign w_sq     = {{ERR_W{1'b0}}, w_abs} * {{ERR_W{1'b0}}, w_abs};

  assign bus.op_a       = r_ops[OPS_W-1:WIDTH];
  assign bus.op_b       = r_ops[WIDTH-1:0];
  assign bus.busy       = w_active;
  assign bus.done       = (r_state == S_DONE);
  assign bus.aborted    = r_aborted;
  assign bus.case_count = r_case_count;
  assign bus.err_count  = r_err_count;
  assign bus.err_sum    = r_err_sum;
  assign bus.abs_sum    = r_abs_sum;
  assign bus.sq_sum     = r_sq_sum;
  assign bus.max_abs    = r_max_abs;

  // next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_SWEEP;
      S_SWEEP: begin
        if (bus.abort)  w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: w_state_nxt = bus.abort ? S_IDLE : S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // operand counter; holds on the last pair and on abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_ops <= '0;
    else if (w_accept)           r_ops <= '0;
    else if (w_run && !w_last)   r_ops <= r_ops + OPS_ONE;
  end

  // stage 1: capture the per-case signed error of the pair currently driven
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_vld <= 1'b0;
      r_s_err <= '0;
    end else if (w_run) begin
      r_s_vld <= 1'b1;
      r_s_err <= w_err;
    end else begin
      r_s_vld <= 1'b0;
    end
  end

  // stage 2: accumulate the captured case; a new run clears the totals
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_case_count <= '0;
      r_err_count  <= '0;
      r_err_sum    <= '0;
      r_abs_sum    <= '0;
      r_sq_sum     <= '0;
      r_max_abs    <= '0;
    end else if (w_accept) begin
      r_case_count <= '0;
      r_err_count  <= '0;
      r_err_sum    <= '0;
      r_abs_sum    <= '0;
      r_sq_sum     <= '0;
      r_max_abs    <= '0;
    end else if (r_s_vld) begin
      r_case_count <= r_case_count + CNT_ONE;
      r_err_count  <= r_err_count + {{(CNT_W-1){1'b0}}, (r_s_err != '0)};
      r_err_sum    <= r_err_sum + {{(ABS_W+1-ERR_W){r_s_err[ERR_W-1]}}, r_s_err};
      r_abs_sum    <= r_abs_sum + {{(ABS_W-ERR_W){1'b0}}, w_abs};
      r_sq_sum     <= r_sq_sum + {{(SQ_W-2*ERR_W){1'b0}}, w_sq};
      if (w_abs > r_max_abs) r_max_abs <= w_abs;
    end
  end

  // sticky abort flag; start in IDLE outranks a simultaneous abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_aborted <= 1'b0;
    else if (w_accept)             r_aborted <= 1'b0;
    else if (w_active && bus.abort) r_aborted <= 1'b1;
  end
endmodule
